// File: rtl/toggle_cover_gen_pkg.sv
// Shared sizing and helpers for the toggle coverage event generator.
// Default monitored width, count-width helper and a fixed-span popcount.
package toggle_cover_pkg;

  localparam int DEFAULT_WIDTH = 23;
  // Widest bundle the popcount helper can count; WIDTH must not exceed it.
  localparam int POP_MAX_W = 256;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cover_gen_if.sv
// Signal bundle between the stimulus side and the toggle coverage generator.
// master drives sig/sample_en/clear; slave (the generator) drives the reports.
interface toggle_cover_gen_if
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
);

  logic [WIDTH-1:0] sig;
  logic             sample_en;
  logic             clear;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  modport master (
    output sig, sample_en, clear,
    input  valid, covered, covered_count, all_covered
  );

  modport slave (
    input  sig, sample_en, clear,
    output valid, covered, covered_count, all_covered
  );

endinterface

// File: rtl/toggle_cover_gen_tracker.sv
// One monitored bit: edge flags, completion pulse one cycle after the completing edge, sticky covered; no backpressure.
// TOGGLE_ONESHOT_EN: suppress further pulses once the bit is covered.
module toggle_bit_tracker (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  input  logic armed,
  input  logic sample_en,
  input  logic clear,
  output logic valid,
  output logic covered
);

  logic prev;
  logic rise;
  logic fall;
  logic r;
  logic f;
  logic done;
  logic report;

  always_comb begin
    r    = armed & sample_en & ~prev & sig;
    f    = armed & sample_en & prev & ~sig;
    done = (rise | r) & (fall | f);
`ifdef TOGGLE_ONESHOT_EN
    report = done & ~covered;
`else
    report = done;
`endif
  end

  // While unarmed, rise/fall are already clear and r/f are forced low, so the
  // armed path below doubles as the arming load of prev.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      covered <= 1'b0;
      valid   <= 1'b0;
    end else if (clear) begin
      rise    <= 1'b0;
      fall    <= 1'b0;
      covered <= 1'b0;
      valid   <= 1'b0;
    end else begin
      prev <= sig;
      if (done) begin
        valid   <= report;
        covered <= 1'b1;
        rise    <= 1'b0;
        fall    <= 1'b0;
      end else begin
        valid <= 1'b0;
        rise  <= rise | r;
        fall  <= fall | f;
      end
    end
  end

endmodule

// File: rtl/toggle_cover_gen.sv
// Toggle-event generator: per-bit rise+fall completion pulses (valid one cycle after the edge, count one more), no backpressure.
// TOGGLE_ONESHOT_EN limits each bit to a single pulse until clear or reset.
module toggle_cover_gen
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  toggle_cover_gen_if.slave bus
);

  logic             armed;
  logic [WIDTH-1:0] valid_w;
  logic [WIDTH-1:0] covered_w;
  logic [CNT_W-1:0] count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_bit_tracker u_trk (
      .clock     (clock),
      .reset     (reset),
      .sig       (bus.sig[i]),
      .armed     (armed),
      .sample_en (bus.sample_en),
      .clear     (bus.clear),
      .valid     (valid_w[i]),
      .covered   (covered_w[i])
    );
  end

  // The first edge out of reset or clear only arms; the trackers load prev then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else begin
      armed <= ~bus.clear;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.clear) begin
      count_q <= '0;
    end else begin
      count_q <= CNT_W'(popcount(POP_MAX_W'(covered_w)));
    end
  end

  assign bus.valid         = valid_w;
  assign bus.covered       = covered_w;
  assign bus.covered_count = count_q;
  assign bus.all_covered   = (count_q == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_gen.sv
// Directed bench for toggle_cover_gen: expectations queued per edge, checked by a monitor 1 time unit after each rising edge.
// Expected pulse patterns follow TOGGLE_ONESHOT_EN when it is defined.
module tb_toggle_cover_gen;

  localparam int W = 23;

  typedef struct {
    int         id;
    logic [W-1:0] v;
    logic [W-1:0] c;
    logic [4:0]   n;
    logic         a;
  } exp_t;

`ifdef TOGGLE_ONESHOT_EN
  localparam logic [W-1:0] REP5   = 23'h000000;
  localparam logic [W-1:0] ALLREP = 23'h7FFFD6;
`else
  localparam logic [W-1:0] REP5   = 23'h000020;
  localparam logic [W-1:0] ALLREP = 23'h7FFFFF;
`endif

  logic clock;
  logic reset;
  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   vid;

  toggle_cover_gen_if bus ();

  toggle_cover_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic rst, input logic [W-1:0] s, input logic en, input logic clr,
                      input logic [W-1:0] ev, input logic [W-1:0] ec, input int n);
    exp_t e;
    @(negedge clock);
    reset         = rst;
    bus.sig       = s;
    bus.sample_en = en;
    bus.clear     = clr;
    e.id = vid;
    e.v  = ev;
    e.c  = ec;
    e.n  = 5'(n);
    e.a  = (n == W);
    vid++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.valid !== e.v || bus.covered !== e.c || bus.covered_count !== e.n ||
            bus.all_covered !== e.a) begin
          miscompares++;
          $display("FAIL vec%0d: got valid=%h covered=%h count=%0d all=%b, expected valid=%h covered=%h count=%0d all=%b",
                   e.id, bus.valid, bus.covered, bus.covered_count, bus.all_covered,
                   e.v, e.c, e.n, e.a);
        end
      end
    end
  end

  initial begin : stimulus
    vectors       = 0;
    miscompares   = 0;
    vid           = 0;
    reset         = 1'b0;
    bus.sig       = '0;
    bus.sample_en = 1'b1;
    bus.clear     = 1'b0;

    for (int i = 0; i < 10; i++) step(1'b0, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);

    // Release with all ones held: the arming edge must absorb the initial value.
    for (int i = 0; i < 3; i++) step(1'b1, 23'h7FFFFF, 1'b1, 1'b0, 23'h0, 23'h0, 0);

    step(1'b1, 23'h0, 1'b1, 1'b1, 23'h0, 23'h0, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);

    step(1'b1, 23'h1, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h1, 23'h1, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h1, 1);

    // Bit 5 toggling every cycle for 8 edges.
    step(1'b1, 23'h20, 1'b1, 1'b0, 23'h0,  23'h1,  1);
    step(1'b1, 23'h0,  1'b1, 1'b0, 23'h20, 23'h21, 1);
    step(1'b1, 23'h20, 1'b1, 1'b0, 23'h0,  23'h21, 2);
    step(1'b1, 23'h0,  1'b1, 1'b0, REP5,   23'h21, 2);
    step(1'b1, 23'h20, 1'b1, 1'b0, 23'h0,  23'h21, 2);
    step(1'b1, 23'h0,  1'b1, 1'b0, REP5,   23'h21, 2);
    step(1'b1, 23'h20, 1'b1, 1'b0, 23'h0,  23'h21, 2);
    step(1'b1, 23'h0,  1'b1, 1'b0, REP5,   23'h21, 2);
    step(1'b1, 23'h0,  1'b1, 1'b0, 23'h0,  23'h21, 2);

    // Bit 3 pulses while sampling is off; a single later rise must not complete.
    step(1'b1, 23'h8, 1'b0, 1'b0, 23'h0, 23'h21, 2);
    step(1'b1, 23'h0, 1'b0, 1'b0, 23'h0, 23'h21, 2);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h21, 2);
    step(1'b1, 23'h8, 1'b1, 1'b0, 23'h0, 23'h21, 2);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h8, 23'h29, 2);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h29, 3);

    step(1'b1, 23'h7FFFFF, 1'b1, 1'b0, 23'h0,  23'h29,     3);
    step(1'b1, 23'h0,      1'b1, 1'b0, ALLREP, 23'h7FFFFF, 3);
    step(1'b1, 23'h0,      1'b1, 1'b0, 23'h0,  23'h7FFFFF, 23);

    // Clear after bit 2 rose; the post-clear fall alone must not report.
    step(1'b1, 23'h4, 1'b1, 1'b0, 23'h0, 23'h7FFFFF, 23);
    step(1'b1, 23'h4, 1'b1, 1'b1, 23'h0, 23'h0, 0);
    step(1'b1, 23'h4, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b1, 23'h4, 1'b1, 1'b0, 23'h4, 23'h4, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h4, 1);

    // Bit 7 completes, then reset lands inside the pulse cycle.
    step(1'b1, 23'h80, 1'b1, 1'b0, 23'h0,  23'h4,  1);
    step(1'b1, 23'h0,  1'b1, 1'b0, 23'h80, 23'h84, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.valid !== 23'h0 || bus.covered !== 23'h0 || bus.covered_count !== 5'd0) begin
      miscompares++;
      $display("FAIL async_rst: got valid=%h covered=%h count=%0d, expected all zero",
               bus.valid, bus.covered, bus.covered_count);
    end
    step(1'b0, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b0, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);
    step(1'b1, 23'h0, 1'b1, 1'b0, 23'h0, 23'h0, 0);

    repeat (3) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
